// File: rtl/reorder_buffer.sv
// ---------------------------------------------------------------------------
// reorder_buffer
//
// Dual-issue, dual-commit reorder buffer. Two dispatch lanes allocate entries
// in program order (lane 0 older), two execution lanes mark entries done with
// their results, and up to two of the oldest done entries retire per cycle as
// register-file writes.
//
// Optional feature macro: ROB_COMMIT_REG_EN
//   undefined : wa/wd are combinational from the head entries.
//   defined   : wa/wd are registered, so they lag the commit by one cycle.
//
// Parameters
//   DEPTH  number of in-flight entries (power of two, >= 4)
//   TAG_W  entry tag width
//
// Ports
//   clk          single clock, rising edge
//   reset        synchronous active-high reset
//   alloc_req    per-lane allocation request
//   alloc_rd     per-lane destination register (0 = no write)
//   alloc_ready  high when at least two entries are free
//   alloc_tag    tag handed to each dispatch lane this cycle
//   cmpl_valid   per-lane completion strobe
//   cmpl_tag     tag of the completing entry
//   cmpl_data    completion result
//   flush        discard every in-flight entry
//   wa / wd      register-file write address / data per commit lane
//   count        number of valid entries
// ---------------------------------------------------------------------------
module reorder_buffer #(
    parameter int DEPTH = 8,
    parameter int TAG_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             alloc_req  [2],
    input  logic [4:0]       alloc_rd   [2],
    output logic             alloc_ready,
    output logic [TAG_W-1:0] alloc_tag  [2],
    input  logic             cmpl_valid [2],
    input  logic [TAG_W-1:0] cmpl_tag   [2],
    input  logic [31:0]      cmpl_data  [2],
    input  logic             flush,
    output logic [4:0]       wa         [2],
    output logic [31:0]      wd         [2],
    output logic [TAG_W:0]   count
);

    logic             valid_q [DEPTH];
    logic             done_q  [DEPTH];
    logic [4:0]       rd_q    [DEPTH];
    logic [31:0]      data_q  [DEPTH];
    logic [TAG_W-1:0] head_q;
    logic [TAG_W-1:0] tail_q;
    logic [TAG_W:0]   count_q;

    logic             accept0;
    logic             accept1;
    logic [1:0]       n_alloc;
    logic [1:0]       n_commit;
    logic [TAG_W-1:0] head_next;
    logic             fire0;
    logic             fire1;
    logic [4:0]       commit_wa [2];
    logic [31:0]      commit_wd [2];

    // Readiness looks only at the registered occupancy so it never depends on
    // this cycle's commits; two free slots guarantee both lanes can be taken.
    assign alloc_ready = (count_q <= (TAG_W+1)'(DEPTH - 2));
    assign count       = count_q;

    // Lane 1 takes the slot after lane 0 only when lane 0 is actually asking.
    assign alloc_tag[0] = tail_q;
    assign alloc_tag[1] = tail_q + TAG_W'(alloc_req[0]);

    assign accept0 = alloc_req[0] && alloc_ready && !flush;
    assign accept1 = alloc_req[1] && alloc_ready && !flush;
    assign n_alloc = {1'b0, accept0} + {1'b0, accept1};

    // Commit selection. Lane 1 is held back when both entries target the same
    // non-zero register, because the register file lets wa[0] win a collision
    // and the younger value would be lost.
    always_comb begin
        head_next = head_q + TAG_W'(1);
        fire0     = !flush && valid_q[head_q] && done_q[head_q];
        fire1     = fire0 && valid_q[head_next] && done_q[head_next] &&
                    ((rd_q[head_q] != rd_q[head_next]) ||
                     (rd_q[head_q] == 5'd0) || (rd_q[head_next] == 5'd0));
        n_commit  = {1'b0, fire0} + {1'b0, fire1};

        commit_wa[0] = 5'd0;
        commit_wd[0] = 32'd0;
        commit_wa[1] = 5'd0;
        commit_wd[1] = 32'd0;
        if (fire0) begin
            commit_wa[0] = rd_q[head_q];
            commit_wd[0] = data_q[head_q];
        end
        if (fire1) begin
            commit_wa[1] = rd_q[head_next];
            commit_wd[1] = data_q[head_next];
        end
    end

    // Entry state. Completions are applied first (lane 1 written last so it
    // wins a shared tag), then commits clear retired slots, then allocations
    // fill the tail. Commit reads the registered done bit, so a result that
    // arrives this cycle can retire at the earliest next cycle.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i] <= 1'b0;
                done_q[i]  <= 1'b0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            for (int l = 0; l < 2; l++) begin
                if (cmpl_valid[l] && valid_q[cmpl_tag[l]]) begin
                    done_q[cmpl_tag[l]] <= 1'b1;
                    data_q[cmpl_tag[l]] <= cmpl_data[l];
                end
            end

            if (fire0) begin
                valid_q[head_q] <= 1'b0;
                done_q[head_q]  <= 1'b0;
            end
            if (fire1) begin
                valid_q[head_next] <= 1'b0;
                done_q[head_next]  <= 1'b0;
            end

            if (accept0) begin
                valid_q[alloc_tag[0]] <= 1'b1;
                done_q[alloc_tag[0]]  <= 1'b0;
                rd_q[alloc_tag[0]]    <= alloc_rd[0];
            end
            if (accept1) begin
                valid_q[alloc_tag[1]] <= 1'b1;
                done_q[alloc_tag[1]]  <= 1'b0;
                rd_q[alloc_tag[1]]    <= alloc_rd[1];
            end

            head_q  <= head_q + TAG_W'(n_commit);
            tail_q  <= tail_q + TAG_W'(n_alloc);
            count_q <= count_q + (TAG_W+1)'(n_alloc) - (TAG_W+1)'(n_commit);
        end
    end

`ifdef ROB_COMMIT_REG_EN
    logic [4:0]  wa_q [2];
    logic [31:0] wd_q [2];

    // Registered write port: the commit already happened in the entry array,
    // these flops only delay its presentation to the register file.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            for (int l = 0; l < 2; l++) begin
                wa_q[l] <= 5'd0;
                wd_q[l] <= 32'd0;
            end
        end else begin
            for (int l = 0; l < 2; l++) begin
                wa_q[l] <= commit_wa[l];
                wd_q[l] <= commit_wd[l];
            end
        end
    end

    assign wa[0] = wa_q[0];
    assign wa[1] = wa_q[1];
    assign wd[0] = wd_q[0];
    assign wd[1] = wd_q[1];
`else
    assign wa[0] = commit_wa[0];
    assign wa[1] = commit_wa[1];
    assign wd[0] = commit_wd[0];
    assign wd[1] = commit_wd[1];
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// ---------------------------------------------------------------------------
// tb_reorder_buffer
//
// Directed bench for reorder_buffer (DEPTH=8). The stimulus process drives
// inputs and pushes every commit it expects into a queue; an independent
// monitor pops that queue whenever the write port shows activity, and also
// keeps a small register-file model with wa[0] priority.
// ---------------------------------------------------------------------------
module tb_reorder_buffer;

    localparam int DEPTH = 8;
    localparam int TAG_W = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             alloc_req  [2];
    logic [4:0]       alloc_rd   [2];
    logic             alloc_ready;
    logic [TAG_W-1:0] alloc_tag  [2];
    logic             cmpl_valid [2];
    logic [TAG_W-1:0] cmpl_tag   [2];
    logic [31:0]      cmpl_data  [2];
    logic             flush;
    logic [4:0]       wa         [2];
    logic [31:0]      wd         [2];
    logic [TAG_W:0]   count;

    typedef struct {
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
    } commit_t;

    commit_t     exp_q [$];
    logic [31:0] rf [32];
    logic        monitor_on;
    int          tests_run    = 0;
    int          tests_failed = 0;

    reorder_buffer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .alloc_req  (alloc_req),
        .alloc_rd   (alloc_rd),
        .alloc_ready(alloc_ready),
        .alloc_tag  (alloc_tag),
        .cmpl_valid (cmpl_valid),
        .cmpl_tag   (cmpl_tag),
        .cmpl_data  (cmpl_data),
        .flush      (flush),
        .wa         (wa),
        .wd         (wd),
        .count      (count)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Single comparison point shared by the stimulus and monitor processes.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drives every DUT input for the coming clock edge.
    task automatic applyStimulus(input logic r0, input logic r1,
                                 input logic [4:0] d0, input logic [4:0] d1,
                                 input logic c0, input logic [2:0] t0, input logic [31:0] x0,
                                 input logic c1, input logic [2:0] t1, input logic [31:0] x1,
                                 input logic fl);
        alloc_req[0]  = r0;
        alloc_req[1]  = r1;
        alloc_rd[0]   = d0;
        alloc_rd[1]   = d1;
        cmpl_valid[0] = c0;
        cmpl_tag[0]   = t0;
        cmpl_data[0]  = x0;
        cmpl_valid[1] = c1;
        cmpl_tag[1]   = t1;
        cmpl_data[1]  = x1;
        flush         = fl;
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pushCommit(input logic [4:0] a0, input logic [31:0] d0,
                              input logic [4:0] a1, input logic [31:0] d1);
        commit_t e;
        e.wa0 = a0;
        e.wd0 = d0;
        e.wa1 = a1;
        e.wd1 = d1;
        exp_q.push_back(e);
    endtask

    // Monitor: any activity on the write port is a commit and must match the
    // oldest outstanding expectation; the register-file model gives wa[0]
    // priority on an address collision.
    always @(negedge clk) begin
        commit_t e;
        if (monitor_on && (wa[0] != 0 || wa[1] != 0 || wd[0] != 0 || wd[1] != 0)) begin
            if (exp_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL unexpected_commit: got wa={%0d,%0d} wd={0x%0h,0x%0h}, expected no commit",
                         wa[0], wa[1], wd[0], wd[1]);
            end else begin
                e = exp_q.pop_front();
                checkOutput("commit_wa0", 32'(wa[0]), 32'(e.wa0));
                checkOutput("commit_wd0", wd[0], e.wd0);
                checkOutput("commit_wa1", 32'(wa[1]), 32'(e.wa1));
                checkOutput("commit_wd1", wd[1], e.wd1);
            end
            if (wa[1] != 0) rf[wa[1]] = wd[1];
            if (wa[0] != 0) rf[wa[0]] = wd[0];
        end
    end

    // Watchdog so the run can never hang.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed stimulus sequence.
    initial begin
        logic [4:0]  rd_a;
        logic [31:0] d_a;
        logic [2:0]  t_a;
        logic [2:0]  t_b;

        monitor_on = 1'b0;
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
        idle();
        reset = 1'b1;
        nextCycle();
        nextCycle();
        @(negedge clk);
        checkOutput("reset_count", 32'(count), 0);
        checkOutput("reset_wa0", 32'(wa[0]), 0);
        checkOutput("reset_wa1", 32'(wa[1]), 0);
        nextCycle();
        reset = 1'b0;
        monitor_on = 1'b1;

        // Out-of-order completion, in-order dual commit.
        applyStimulus(1, 1, 5, 6, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("post_reset_ready", 32'(alloc_ready), 1);
        checkOutput("post_reset_tag0", 32'(alloc_tag[0]), 0);
        checkOutput("post_reset_tag1", 32'(alloc_tag[1]), 1);
        checkOutput("post_reset_wd0", wd[0], 0);
        checkOutput("post_reset_wd1", wd[1], 0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 1, 1, 32'hBB, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("t1_count", 32'(count), 2);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 1, 0, 32'hAA, 0, 0, 0, 0);
        pushCommit(5, 32'hAA, 6, 32'hBB);
        @(negedge clk);
        nextCycle();
        idle();
        @(negedge clk);
        nextCycle();
        @(negedge clk);
        checkOutput("t1_count_drained", 32'(count), 0);
        checkOutput("t1_rf5", rf[5], 32'hAA);
        checkOutput("t1_rf6", rf[6], 32'hBB);
        nextCycle();

        // Same destination in adjacent entries retires one per cycle.
        applyStimulus(1, 1, 7, 7, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("t3_tag0", 32'(alloc_tag[0]), 2);
        checkOutput("t3_tag1", 32'(alloc_tag[1]), 3);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 1, 2, 32'd1, 1, 3, 32'd2, 0);
        pushCommit(7, 32'd1, 0, 32'd0);
        pushCommit(7, 32'd2, 0, 32'd0);
        @(negedge clk);
        nextCycle();
        idle();
        repeat (2) begin
            @(negedge clk);
            nextCycle();
        end
        @(negedge clk);
        checkOutput("t3_rf7", rf[7], 32'd2);
        checkOutput("t3_count", 32'(count), 0);
        nextCycle();

        // Completion to an unallocated tag is ignored.
        applyStimulus(0, 0, 0, 0, 1, 3, 32'h33, 0, 0, 0, 0);
        @(negedge clk);
        nextCycle();
        idle();
        @(negedge clk);
        checkOutput("t6_count", 32'(count), 0);
        checkOutput("t6_tail", 32'(alloc_tag[0]), 4);
        nextCycle();
        @(negedge clk);
        nextCycle();

        // rd=0 entry commits with wa=0; shared completion tag, lane 1 wins.
        applyStimulus(1, 1, 0, 9, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("t7_tag0", 32'(alloc_tag[0]), 4);
        checkOutput("t7_tag1", 32'(alloc_tag[1]), 5);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 1, 5, 32'h55, 0, 0, 0, 0);
        @(negedge clk);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 1, 4, 32'h11, 1, 4, 32'h22, 0);
        pushCommit(0, 32'h22, 9, 32'h55);
        @(negedge clk);
        nextCycle();
        idle();
        @(negedge clk);
        nextCycle();
        @(negedge clk);
        checkOutput("t7_rf9", rf[9], 32'h55);
        checkOutput("t7_rf0", rf[0], 32'd0);
        checkOutput("t7_count", 32'(count), 0);
        nextCycle();

        // Fill to capacity; a further request is ignored.
        for (int p = 0; p < 4; p++) begin
            applyStimulus(1, 1, 5'(1 + 2 * p), 5'(2 + 2 * p), 0, 0, 0, 0, 0, 0, 0);
            @(negedge clk);
            checkOutput("full_ready", 32'(alloc_ready), 1);
            checkOutput("full_tag0", 32'(alloc_tag[0]), (6 + 2 * p) % 8);
            checkOutput("full_tag1", 32'(alloc_tag[1]), (7 + 2 * p) % 8);
            checkOutput("full_count", 32'(count), 2 * p);
            nextCycle();
        end
        applyStimulus(1, 1, 10, 11, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("full_count8", 32'(count), 8);
        checkOutput("full_not_ready", 32'(alloc_ready), 0);
        nextCycle();
        idle();
        @(negedge clk);
        checkOutput("full_count_held", 32'(count), 8);
        checkOutput("full_tail_held", 32'(alloc_tag[0]), 6);
        nextCycle();

        // Retire three entries, leaving five valid for the flush.
        applyStimulus(0, 0, 0, 0, 1, 6, 32'h61, 1, 7, 32'h71, 0);
        pushCommit(1, 32'h61, 2, 32'h71);
        @(negedge clk);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 1, 0, 32'h01, 0, 0, 0, 0);
        pushCommit(3, 32'h01, 0, 32'd0);
        @(negedge clk);
        nextCycle();
        idle();
        @(negedge clk);
        checkOutput("pre_flush_count6", 32'(count), 6);
        checkOutput("pre_flush_ready", 32'(alloc_ready), 1);
        nextCycle();

        // Flush with a same-cycle allocation and completion.
        applyStimulus(1, 1, 12, 13, 1, 1, 32'hDD, 0, 0, 0, 1);
        @(negedge clk);
        checkOutput("flush_count5", 32'(count), 5);
        nextCycle();
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("flush_count0", 32'(count), 0);
        checkOutput("flush_tag0", 32'(alloc_tag[0]), 0);
        checkOutput("flush_tag1", 32'(alloc_tag[1]), 1);
        checkOutput("flush_wa0", 32'(wa[0]), 0);
        checkOutput("flush_wa1", 32'(wa[1]), 0);
        idle();
        nextCycle();

        // Twenty alloc/complete/commit pairs around the ring.
        for (int i = 0; i < 20; i++) begin
            rd_a = 5'((i % 15) * 2 + 1);
            d_a  = 32'h1000 + 32'(2 * i);
            t_a  = 3'((2 * i) % 8);
            t_b  = t_a + 3'd1;
            applyStimulus(1, 1, rd_a, rd_a + 5'd1, 0, 0, 0, 0, 0, 0, 0);
            @(negedge clk);
            checkOutput("wrap_tag0", 32'(alloc_tag[0]), 32'(t_a));
            checkOutput("wrap_tag1", 32'(alloc_tag[1]), 32'(t_b));
            checkOutput("wrap_count_start", 32'(count), 0);
            nextCycle();
            applyStimulus(0, 0, 0, 0, 1, t_a, d_a, 1, t_b, d_a + 32'd1, 0);
            pushCommit(rd_a, d_a, rd_a + 5'd1, d_a + 32'd1);
            @(negedge clk);
            checkOutput("wrap_count_inflight", 32'(count), 2);
            nextCycle();
            idle();
            @(negedge clk);
            nextCycle();
        end

        repeat (3) nextCycle();
        checkOutput("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
